display_hdmi_rgb_to_yuv_cfg: RTL



---
 rtl/display_hdmi_yuv_pkg.sv | 65 ++++++
 rtl/display_hdmi_csc_mac.sv | 88 ++++++++
 rtl/display_hdmi_rgb_to_yuv_cfg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/display_hdmi_yuv_pkg.sv
// Shared types and constants for the HDMI RGB-to-YCbCr path: coefficient tables,
// pipeline latency, and limited-range offset/clamp levels scaled to the component width.
package display_hdmi_yuv_pkg;

    localparam int unsigned LAT     = 6;
    localparam int unsigned MAC_LAT = 4;
    localparam int unsigned COEF_W  = 12;
    localparam int unsigned FRAC_W  = 10;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic {
        StdBt601 = 1'b0,
        StdBt709 = 1'b1
    } color_std_e;

    // Row-major: Y(R,G,B), Cb(R,G,B), Cr(R,G,B), scaled by 1024
    localparam coef_t COEF_BT601 [9] = '{
        12'sd263,  12'sd516,  12'sd100,
        -12'sd152, -12'sd298, 12'sd450,
        12'sd450,  -12'sd377, -12'sd73
    };

    localparam coef_t COEF_BT709 [9] = '{
        12'sd187,  12'sd629,  12'sd63,
        -12'sd103, -12'sd347, 12'sd450,
        12'sd450,  -12'sd409, -12'sd41
    };

    typedef struct packed {
        logic de;
        logic vs;
        logic hs;
        logic mode422;
    } sync_t;

    function automatic coef_t get_coef(color_std_e std, logic [3:0] idx);
        return (std == StdBt709) ? COEF_BT709[idx] : COEF_BT601[idx];
    endfunction

    function automatic int y_offset(int unsigned dw);
        return 16 << (dw - 8);
    endfunction

    function automatic int c_offset(int unsigned dw);
        return 128 << (dw - 8);
    endfunction

    function automatic int y_min(int unsigned dw);
        return 16 << (dw - 8);
    endfunction

    function automatic int y_max(int unsigned dw);
        return 235 << (dw - 8);
    endfunction

    function automatic int c_min(int unsigned dw);
        return 16 << (dw - 8);
    endfunction

    function automatic int c_max(int unsigned dw);
        return 240 << (dw - 8);
    endfunction

endpackage

// File: rtl/display_hdmi_csc_mac.sv
// 3x3 colour matrix: input register, products, sums, then round/offset/clamp.
// Four register stages from RGB in to Y/Cb/Cr out.
module display_hdmi_csc_mac
    import display_hdmi_yuv_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COLOR_STD = 0
) (
    input  logic              iHdmiClk,
    input  logic              iRst_n,
    input  logic [DATA_W-1:0] ivRed,
    input  logic [DATA_W-1:0] ivGreen,
    input  logic [DATA_W-1:0] ivBlue,
    output logic [DATA_W-1:0] ovY,
    output logic [DATA_W-1:0] ovCb,
    output logic [DATA_W-1:0] ovCr
);

    localparam int unsigned AccW = DATA_W + 12;
    typedef logic signed [AccW-1:0] acc_t;

    localparam color_std_e Std   = (COLOR_STD == 1) ? StdBt709 : StdBt601;
    localparam acc_t       Round = acc_t'(1 << (FRAC_W - 1));
    localparam acc_t       YOff  = acc_t'(y_offset(DATA_W));
    localparam acc_t       COff  = acc_t'(c_offset(DATA_W));
    localparam acc_t       YLo   = acc_t'(y_min(DATA_W));
    localparam acc_t       YHi   = acc_t'(y_max(DATA_W));
    localparam acc_t       CLo   = acc_t'(c_min(DATA_W));
    localparam acc_t       CHi   = acc_t'(c_max(DATA_W));

    logic [DATA_W-1:0] comp_d [3];
    logic [DATA_W-1:0] comp_q [3];
    acc_t              prod_d [9];
    acc_t              prod_q [9];
    acc_t              sum_d  [3];
    acc_t              sum_q  [3];
    logic [DATA_W-1:0] res_d  [3];
    logic [DATA_W-1:0] res_q  [3];

    function automatic logic [DATA_W-1:0] round_clamp(acc_t s, acc_t off, acc_t lo, acc_t hi);
        acc_t v;
        v = (s >>> FRAC_W) + off;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return DATA_W'(v);
    endfunction

    always_comb begin
        comp_d[0] = ivRed;
        comp_d[1] = ivGreen;
        comp_d[2] = ivBlue;
        // Components are unsigned, so zero-extend before the signed multiply
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) begin
                prod_d[3*c+k] = acc_t'(get_coef(Std, 4'(3*c+k))) * acc_t'({1'b0, comp_q[k]});
            end
        end
        for (int c = 0; c < 3; c++) begin
            sum_d[c] = prod_q[3*c] + prod_q[3*c+1] + prod_q[3*c+2] + Round;
        end
        res_d[0] = round_clamp(sum_q[0], YOff, YLo, YHi);
        res_d[1] = round_clamp(sum_q[1], COff, CLo, CHi);
        res_d[2] = round_clamp(sum_q[2], COff, CLo, CHi);
    end

    always_ff @(posedge iHdmiClk) begin
        if (!iRst_n) begin
            for (int i = 0; i < 3; i++) begin
                comp_q[i] <= '0;
                sum_q[i]  <= '0;
                res_q[i]  <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            comp_q <= comp_d;
            prod_q <= prod_d;
            sum_q  <= sum_d;
            res_q  <= res_d;
        end
    end

    assign ovY  = res_q[0];
    assign ovCb = res_q[1];
    assign ovCr = res_q[2];

endmodule

// File: rtl/display_hdmi_rgb_to_yuv_cfg.sv
// HDMI output colour converter: RGB to limited-range YCbCr 4:4:4 or 4:2:2, with
// timing delayed to match the six-stage data path, per-frame mode capture and frame count.
module display_hdmi_rgb_to_yuv_cfg
    import display_hdmi_yuv_pkg::*;
#(
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned COLOR_STD        = 0,
    parameter bit          IN_SYNC_ACT_HIGH = 1'b1,
    parameter bit          OUT_SYNC_INV     = 1'b1,
    parameter bit          CHROMA_AVG       = 1'b1
) (
    input  logic                iHdmiClk,
    input  logic                iRst_n,
    input  logic                iMode422,
    input  logic [DATA_W-1:0]   ivRed,
    input  logic [DATA_W-1:0]   ivGreen,
    input  logic [DATA_W-1:0]   ivBlue,
    input  logic                iRgbDe,
    input  logic                iRgbVs,
    input  logic                iRgbHs,
    output logic                oYuvDe,
    output logic                oYuvVs,
    output logic                oYuvHs,
    output logic [3*DATA_W-1:0] ovYuvData,
    output logic                oMode422,
    output logic [15:0]         ov16FrameCnt,
    output logic                oOddLineErr
);

    localparam int unsigned S4 = MAC_LAT - 1;
    localparam int unsigned S5 = MAC_LAT;
    localparam int unsigned S6 = LAT - 1;

    localparam sync_t SyncRst = '{
        de: 1'b0, vs: ~IN_SYNC_ACT_HIGH, hs: ~IN_SYNC_ACT_HIGH, mode422: 1'b0
    };

    sync_t sync_d [LAT];
    sync_t sync_q [LAT];

    logic [DATA_W-1:0] mac_y, mac_cb, mac_cr;
    logic [DATA_W-1:0] y5_d, y5_q, cb5_d, cb5_q, cr5_d, cr5_q;
    logic              phase_d, phase_q;
    logic [DATA_W-1:0] cr_hold_d, cr_hold_q;
    logic [3*DATA_W-1:0] data_d, data_q;
    logic              odd_pend_d, odd_pend_q;
    logic              err_d, err_q;
    logic              mode_cap_d, mode_cap_q;
    logic [15:0]       frame_cnt_d, frame_cnt_q;

    logic              vs_lead;
    logic [DATA_W-1:0] cb_part, cr_part;
    logic [DATA_W:0]   cb_sum, cr_sum;

    display_hdmi_csc_mac #(
        .DATA_W    (DATA_W),
        .COLOR_STD (COLOR_STD)
    ) u_csc_mac (
        .iHdmiClk (iHdmiClk),
        .iRst_n   (iRst_n),
        .ivRed    (ivRed),
        .ivGreen  (ivGreen),
        .ivBlue   (ivBlue),
        .ovY      (mac_y),
        .ovCb     (mac_cb),
        .ovCr     (mac_cr)
    );

    // Timing pipeline; the mode bit travels with each pixel so a frame boundary
    // inside the pipeline never mixes formats.
    always_comb begin
        vs_lead    = (iRgbVs == IN_SYNC_ACT_HIGH) && (sync_q[0].vs != IN_SYNC_ACT_HIGH);
        mode_cap_d = vs_lead ? iMode422 : mode_cap_q;
        sync_d[0].de      = iRgbDe;
        sync_d[0].vs      = iRgbVs;
        sync_d[0].hs      = iRgbHs;
        sync_d[0].mode422 = mode_cap_d;
        for (int k = 1; k < LAT; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // S5 holds the current pixel while its pair partner sits in the MAC output.
    always_comb begin
        y5_d    = mac_y;
        cb5_d   = mac_cb;
        cr5_d   = mac_cr;
        phase_d = sync_q[S4].de & sync_q[S5].de & ~phase_q;
    end

    always_comb begin
        data_d     = '0;
        cr_hold_d  = cr_hold_q;
        odd_pend_d = 1'b0;
        // A lone last pixel pairs with itself
        cb_part    = sync_q[S4].de ? mac_cb : cb5_q;
        cr_part    = sync_q[S4].de ? mac_cr : cr5_q;
        cb_sum     = {1'b0, cb5_q} + {1'b0, cb_part} + (DATA_W+1)'(1);
        cr_sum     = {1'b0, cr5_q} + {1'b0, cr_part} + (DATA_W+1)'(1);
        if (sync_q[S5].de) begin
            if (!sync_q[S5].mode422) begin
                data_d = {cr5_q, cb5_q, y5_q};
            end else if (!phase_q) begin
                if (CHROMA_AVG) begin
                    data_d    = {{DATA_W{1'b0}}, DATA_W'(cb_sum >> 1), y5_q};
                    cr_hold_d = DATA_W'(cr_sum >> 1);
                end else begin
                    data_d    = {{DATA_W{1'b0}}, cb5_q, y5_q};
                    cr_hold_d = cr5_q;
                end
                odd_pend_d = ~sync_q[S4].de;
            end else begin
                data_d = {{DATA_W{1'b0}}, cr_hold_q, y5_q};
            end
        end
        err_d       = odd_pend_q;
        frame_cnt_d = frame_cnt_q;
        if ((sync_q[S5].vs == IN_SYNC_ACT_HIGH) && (sync_q[S6].vs != IN_SYNC_ACT_HIGH)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iHdmiClk) begin
        if (!iRst_n) begin
            for (int k = 0; k < LAT; k++) begin
                sync_q[k] <= SyncRst;
            end
            y5_q        <= '0;
            cb5_q       <= '0;
            cr5_q       <= '0;
            phase_q     <= 1'b0;
            cr_hold_q   <= '0;
            data_q      <= '0;
            odd_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            mode_cap_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sync_q      <= sync_d;
            y5_q        <= y5_d;
            cb5_q       <= cb5_d;
            cr5_q       <= cr5_d;
            phase_q     <= phase_d;
            cr_hold_q   <= cr_hold_d;
            data_q      <= data_d;
            odd_pend_q  <= odd_pend_d;
            err_q       <= err_d;
            mode_cap_q  <= mode_cap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oYuvDe       = sync_q[S6].de;
    assign oYuvVs       = sync_q[S6].vs ^ OUT_SYNC_INV;
    assign oYuvHs       = sync_q[S6].hs ^ OUT_SYNC_INV;
    assign ovYuvData    = data_q;
    assign oMode422     = sync_q[S6].mode422;
    assign ov16FrameCnt = frame_cnt_q;
    assign oOddLineErr  = err_q;

endmodule
